// File: rtl/cl_pkg.sv
// Shared constants, state encoding and sizing helper for the Camera Link frame transmitter.
package cl_pkg;

  // Layout of the 28-bit Camera Link tx word
  localparam int unsigned TX_W      = 28;
  localparam int unsigned DATA_W    = 24;
  localparam int unsigned LVAL_BIT  = 24;
  localparam int unsigned FVAL_BIT  = 25;
  localparam int unsigned DVAL_BIT  = 26;
  localparam int unsigned SPARE_BIT = 27;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SYNC,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VBLANK
  } state_e;

  // Bits needed for a counter that runs 0..n-1 (at least 1 bit)
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level, followed by a one-cycle rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  // Synchroniser chain plus one delay stage for the edge compare
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= d;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;

endmodule

// File: rtl/cameralink_frame_tx.sv
// Camera Link base-configuration frame transmitter: FWFT FIFO pixels to a framed 28-bit tx bus.
module cameralink_frame_tx
  import cl_pkg::*;
#(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned TAPS        = 1,
  parameter int unsigned LINE_PIX    = 640,
  parameter int unsigned FRAME_LINES = 480,
  parameter int unsigned HBLANK      = 16,
  parameter int unsigned VBLANK      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    sync_mode,
  input  logic                    sync_out,
  input  logic [TAPS*PIX_W-1:0]   fifo_dout,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  output logic [TX_W-1:0]         tx,
  output logic                    cc_en,
  output logic                    ccen_n,
  output logic                    pwr_dwn_n,
  output logic                    underflow,
  output logic [15:0]             frame_cnt,
  output logic                    busy
);

  localparam int unsigned BEATS     = LINE_PIX / TAPS;
  localparam int unsigned BEAT_W    = cnt_w(BEATS);
  localparam int unsigned LINE_W    = cnt_w(FRAME_LINES);
  localparam int unsigned BLANK_MAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int unsigned BLANK_W   = cnt_w(BLANK_MAX);

  state_e               state;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [LINE_W-1:0]    line_cnt;
  logic [BLANK_W-1:0]   blank_cnt;
  logic                 sync_rise;

  sync_edge_det u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sync_out),
    .rise (sync_rise)
  );

  assign fifo_rd_en = (state == ST_ACTIVE) && !fifo_empty && !rst;
  assign busy       = (state != ST_IDLE);

  // Frame sequencer with registered tx word, counters and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tx        <= '0;
      beat_cnt  <= '0;
      line_cnt  <= '0;
      blank_cnt <= '0;
      frame_cnt <= '0;
      underflow <= 1'b0;
      cc_en     <= 1'b0;
      ccen_n    <= 1'b1;
      pwr_dwn_n <= 1'b0;
    end else begin
      cc_en     <= 1'b1;
      ccen_n    <= 1'b0;
      pwr_dwn_n <= 1'b1;
      tx        <= '0;
      case (state)
        ST_IDLE: begin
          if (enable) state <= sync_mode ? ST_WAIT_SYNC : ST_ACTIVE;
        end
        ST_WAIT_SYNC: begin
          if (!enable)        state <= ST_IDLE;
          else if (sync_rise) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          tx[LVAL_BIT]  <= 1'b1;
          tx[FVAL_BIT]  <= 1'b1;
          tx[SPARE_BIT] <= 1'b0;
          if (fifo_rd_en) begin
            tx[DATA_W-1:0] <= DATA_W'(fifo_dout);
            tx[DVAL_BIT]   <= 1'b1;
            if (beat_cnt == BEAT_W'(BEATS - 1)) begin
              beat_cnt <= '0;
              if (line_cnt == LINE_W'(FRAME_LINES - 1)) begin
                line_cnt  <= '0;
                frame_cnt <= frame_cnt + 16'd1;
                state     <= ST_VBLANK;
              end else begin
                state <= ST_HBLANK;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else begin
            // Stalled beat: framing held, data suppressed, line not shortened
            underflow <= 1'b1;
          end
        end
        ST_HBLANK: begin
          tx[FVAL_BIT] <= 1'b1;
          if (blank_cnt == BLANK_W'(HBLANK - 1)) begin
            blank_cnt <= '0;
            line_cnt  <= line_cnt + 1'b1;
            state     <= ST_ACTIVE;
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        ST_VBLANK: begin
          if (blank_cnt == BLANK_W'(VBLANK - 1)) begin
            blank_cnt <= '0;
            state     <= ST_IDLE;
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cameralink_frame_tx.sv
// Self-checking bench for cameralink_frame_tx: directed sequence with randomized pixel data and stalls.
module tb_cameralink_frame_tx;

  localparam int BEATS  = 8;
  localparam int LINES  = 2;
  localparam int HB     = 3;
  localparam int VB     = 4;
  localparam int NWORDS = 96;
  localparam logic [27:0] LV = 28'h100_0000;
  localparam logic [27:0] FV = 28'h200_0000;
  localparam logic [27:0] DV = 28'h400_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Primary DUT: 1 tap x 8 bits, 8-pixel lines, 2 lines per frame
  logic        rst, enable, sync_mode, sync_out;
  logic [7:0]  fifo_dout;
  logic        fifo_empty, fifo_rd_en;
  logic [27:0] tx;
  logic        cc_en, ccen_n, pwr_dwn_n, underflow, busy;
  logic [15:0] frame_cnt;

  // Second DUT: 2 taps x 12 bits, single-line frames
  logic        enable2;
  logic [23:0] fifo2_dout;
  logic        fifo2_empty, fifo2_rd_en;
  logic [27:0] tx2;
  logic        cc_en2, ccen_n2, pwr_dwn_n2, underflow2, busy2;
  logic [15:0] frame_cnt2;

  cameralink_frame_tx #(
    .PIX_W(8), .TAPS(1), .LINE_PIX(8), .FRAME_LINES(2), .HBLANK(3), .VBLANK(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sync_mode(sync_mode), .sync_out(sync_out),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .tx(tx),
    .cc_en(cc_en), .ccen_n(ccen_n), .pwr_dwn_n(pwr_dwn_n), .underflow(underflow),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  cameralink_frame_tx #(
    .PIX_W(12), .TAPS(2), .LINE_PIX(8), .FRAME_LINES(1), .HBLANK(1), .VBLANK(1)
  ) dut2 (
    .clk(clk), .rst(rst), .enable(enable2), .sync_mode(1'b0), .sync_out(1'b0),
    .fifo_dout(fifo2_dout), .fifo_empty(fifo2_empty), .fifo_rd_en(fifo2_rd_en), .tx(tx2),
    .cc_en(cc_en2), .ccen_n(ccen_n2), .pwr_dwn_n(pwr_dwn_n2), .underflow(underflow2),
    .frame_cnt(frame_cnt2), .busy(busy2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // FIFO models: word arrays indexed by pop count, with optional forced-empty stalls
  logic [7:0]  words [NWORDS];
  int          stall_len [NWORDS];
  logic [23:0] words2 [4];
  int          rd_idx = 0;
  int          stall_left = 0;
  int          rd2 = 0;
  bit          pop_flag = 1'b0;
  bit          pop2 = 1'b0;
  logic [27:0] exp_q [$];

  assign fifo_empty  = (rd_idx >= NWORDS) || (stall_left > 0);
  assign fifo_dout   = (rd_idx < NWORDS) ? words[rd_idx] : 8'h00;
  assign fifo2_empty = (rd2 >= 4);
  assign fifo2_dout  = (rd2 < 4) ? words2[rd2] : 24'h0;

  always @(posedge clk) begin
    pop_flag <= fifo_rd_en;
    pop2     <= fifo2_rd_en;
  end

  always @(negedge clk) begin
    if (pop_flag) begin
      rd_idx++;
      stall_left = (rd_idx < NWORDS) ? stall_len[rd_idx] : 0;
    end else if (stall_left > 0) begin
      stall_left--;
    end
    if (pop2) rd2++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Reference: expand one frame into its expected per-cycle tx words, return index of last beat
  function automatic int add_frame(input int first);
    int k = first;
    for (int l = 0; l < LINES; l++) begin
      for (int b = 0; b < BEATS; b++) begin
        repeat (stall_len[k]) exp_q.push_back(FV | LV);
        exp_q.push_back(DV | FV | LV | 28'(words[k]));
        k++;
      end
      if (l < LINES - 1) repeat (HB) exp_q.push_back(FV);
    end
    return exp_q.size() - 1;
  endfunction

  function automatic void add_zeros(input int n);
    repeat (n) exp_q.push_back(28'h0);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int end1, f2start, drop_at, end3, end4, nd, guard, k;

    rst = 1'b1; enable = 1'b0; sync_mode = 1'b0; sync_out = 1'b0; enable2 = 1'b0;
    for (int i = 0; i < NWORDS; i++) begin
      words[i]     = (i < 16) ? 8'(i + 1) : 8'($urandom_range(1, 255));
      stall_len[i] = 0;
    end
    stall_len[3] = 2;
    k = 16 + int'($urandom_range(1, 7));
    stall_len[k] = int'($urandom_range(1, 3));
    k = 24 + int'($urandom_range(1, 7));
    stall_len[k] = int'($urandom_range(1, 3));
    words2[0] = 24'hBBBAAA;
    for (int i = 1; i < 4; i++) words2[i] = 24'($urandom);

    // Reset values
    repeat (3) tick();
    check("rst_tx", 32'(tx), 32'h0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_underflow", 32'(underflow), 32'h0);
    check("rst_cc_en", 32'(cc_en), 32'h0);
    check("rst_ccen_n", 32'(ccen_n), 32'h1);
    check("rst_pwr_dwn_n", 32'(pwr_dwn_n), 32'h0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'h0);
    rst = 1'b0;
    tick();
    check("run_cc_en", 32'(cc_en), 32'h1);
    check("run_ccen_n", 32'(ccen_n), 32'h0);
    check("run_pwr_dwn_n", 32'(pwr_dwn_n), 32'h1);

    // Two-tap, 12-bit pixels: 4 beats per line, taps packed low-first
    enable2 = 1'b1;
    tick();
    enable2 = 1'b0;
    check("tap2_lead", 32'(tx2), 32'h0);
    for (int b = 0; b < 4; b++) begin
      tick();
      check("tap2_beat", 32'(tx2), 32'(DV | FV | LV | 28'(words2[b])));
    end
    tick();
    check("tap2_tail", 32'(tx2), 32'h0);
    check("tap2_frame_cnt", 32'(frame_cnt2), 32'h1);
    repeat (2) tick();
    check("tap2_busy", 32'(busy2), 32'h0);

    // Free-run: two frames with stalls, enable dropped during line 0 of the second
    exp_q.delete();
    add_zeros(1);
    end1 = add_frame(0);
    add_zeros(VB + 1);
    f2start = exp_q.size();
    void'(add_frame(16));
    add_zeros(VB + 6);
    drop_at = f2start + 2;
    enable = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      check("free_tx", 32'(tx), 32'(exp_q[i]));
      if (i == end1) check("free_frame_cnt1", 32'(frame_cnt), 32'h1);
      if (i == drop_at) enable = 1'b0;
      if (i >= exp_q.size() - 6) check("free_rd_en_idle", 32'(fifo_rd_en), 32'h0);
    end
    check("free_busy", 32'(busy), 32'h0);
    check("free_frame_cnt2", 32'(frame_cnt), 32'h2);
    check("free_underflow", 32'(underflow), 32'h1);

    // External sync: latency from sync_out rise, mid-frame pulse ignored
    sync_mode = 1'b1;
    enable = 1'b1;
    repeat (5) tick();
    check("sync_wait_busy", 32'(busy), 32'h1);
    check("sync_wait_tx", 32'(tx), 32'h0);
    check("sync_wait_rd_en", 32'(fifo_rd_en), 32'h0);
    exp_q.delete();
    add_zeros(3);
    end3 = add_frame(32);
    add_zeros(VB + 12);
    sync_out = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      check("sync_tx", 32'(tx), 32'(exp_q[i]));
      if (i == 10) sync_out = 1'b0;
      if (i == 14) sync_out = 1'b1;
    end
    check("sync_end3", 32'(end3), 32'(3 + 2 * BEATS + HB - 1));
    check("sync_busy_waiting", 32'(busy), 32'h1);
    check("sync_frame_cnt", 32'(frame_cnt), 32'h3);
    check("sync_underflow_sticky", 32'(underflow), 32'h1);

    // Reset on beat 5 of a free-run frame, then a clean restart
    enable = 1'b0;
    tick();
    sync_mode = 1'b0;
    enable = 1'b1;
    nd = 0;
    guard = 0;
    while (nd < 5 && guard < 100) begin
      tick();
      guard++;
      if (tx[26]) nd++;
    end
    check("pre_rst_beats", 32'(nd), 32'h5);
    rst = 1'b1;
    tick();
    check("mid_rst_tx", 32'(tx), 32'h0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'h0);
    check("mid_rst_underflow", 32'(underflow), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_rd_en", 32'(fifo_rd_en), 32'h0);
    check("mid_rst_cc_en", 32'(cc_en), 32'h0);
    rst = 1'b0;
    exp_q.delete();
    add_zeros(1);
    end4 = add_frame(53);
    add_zeros(VB + 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      check("restart_tx", 32'(tx), 32'(exp_q[i]));
      if (i == end4) check("restart_frame_cnt", 32'(frame_cnt), 32'h1);
    end
    check("restart_underflow", 32'(underflow), 32'h0);
    enable = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
